serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
- Bit-serial sequencer for the team's 1-bit ALU slice (alu1Bit): streams two WIDTH-bit operands through one external slice, LSB first, one bit per cycle.
- Carries the slice's carry-out back into its carry-in and assembles the WIDTH-bit result plus flags.
- Sits between the lab datapath/control unit (valid/ready request side) and a single alu1Bit instance. Area is traded for WIDTH+1 cycles of latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width (derived, do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request (high only in IDLE).
- op  input  4  ALUOp for the whole operation. [3]=invert a, [2]=invert b, [1:0]=00 AND / 01 OR / 10 ADD. Examples: 0010 add, 0110 sub, 1100 NOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  assembled result.
- zero  output  1  result == 0.
- carry  output  1  final slice carry-out (ADD-class ops only, else 0).
- overflow  output  1  signed overflow (ADD-class ops only, else 0).
- alu_a  output  1  to slice a.
- alu_b  output  1  to slice b.
- alu_cin  output  1  to slice carryIn.
- alu_op  output  4  to slice ALUOp.
- alu_result  input  1  from slice result.
- alu_cout  input  1  from slice carryOut.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: result=0, zero=0, carry=0, overflow=0, out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_cin=0, alu_op=0. Internal shift registers, bit counter and carry_q are also 0.
- IDLE: in_ready=1. When in_valid&in_ready at a clock edge:
  - load a_sh=a, b_sh=b, op_q=op, cnt=0;
  - carry_q = (op[1:0]==10) & op[2], i.e. 1 for subtract;
  - go to RUN.
- RUN, combinational drive to the slice: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry_q, alu_op=op_q.
- RUN, each edge:
  - shift a_sh and b_sh right;
  - res_sh <= {alu_result, res_sh[WIDTH-1:1]};
  - carry_q <= alu_cout; cnt++.
- RUN, final bit (cnt==WIDTH-1): additionally capture cin_msb=carry_q and cout=alu_cout, then go to DONE.
- RUN lasts exactly WIDTH cycles. Latency from accept edge to out_valid rising is WIDTH+1 edges.
- Outside RUN: alu_a/alu_b/alu_cin=0; alu_op holds op_q.
- DONE, registered outputs:
  - result = res_sh;
  - zero = (res_sh==0);
  - ADD-class ops (op_q[1:0]==10): carry = cout, overflow = cin_msb ^ cout;
  - all other ops: carry = 0, overflow = 0.
- DONE handshake: out_valid=1, outputs held stable until out_valid&out_ready. On that edge go to IDLE and drop out_valid. result and flags keep their last values until the next DONE.
- Back-to-back: a new request is accepted no earlier than the cycle after the handshake (IDLE). No accept in DONE.
- in_valid, a, b, op are ignored outside IDLE.
- op[1:0]==11 (no feature): slice returns 0 per bit; controller still runs WIDTH cycles, result=0, zero=1, carry=overflow=0.
- Asynchronous reset mid-RUN or mid-DONE: immediate return to IDLE with reset values. The partial result is discarded and no out_valid pulse occurs.

Optional Feature:
- Macro: SERIAL_ALU_SLT_EN.
- Defined: op==0111 means set-less-than.
  - Slice is driven with alu_op=0110 and cin=1, i.e. a-b.
  - At DONE: result = {WIDTH-1 zeros, msb_result ^ overflow_sub}; carry=0, overflow=0; zero computed on the final result.
- Undefined: 0111 behaves as any [1:0]==11 op (result 0).

Test Plan:
- WIDTH=8, add: a=8'h7F, b=8'h01, op=0010 -> out_valid exactly 9 edges after accept; result=8'h80, carry=0, overflow=1, zero=0.
- Subtract: a=8'h05, b=8'h05, op=0110 -> result=8'h00, zero=1, carry=1, overflow=0. The first RUN cycle shows alu_cin=1, alu_b=~b[0] at slice.
- Logic ops: a=8'hF0, b=8'h3C; op=0000 -> 8'h30; op=0001 -> 8'hFC; op=1100 -> 8'h03. carry=overflow=0 in all three.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0. A new in_valid is ignored. Accept on out_ready=1, then the next request is accepted one cycle later.
- Reset: assert rst_n=0 at cnt=3 of an add -> outputs immediately at reset values, in_ready=1. A following request a=8'h02, b=8'h03 add yields 8'h05.
- SERIAL_ALU_SLT_EN: a=8'hFE (-2), b=8'h01, op=0111 -> result=8'h01. Swapping operands -> result=8'h00, zero=1.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
// Optional set-less-than (op 0111) when SERIAL_ALU_SLT_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// RUN   | one operand bit per cycle through the slice, carry fed back
// DONE  | result and flags held with out_valid until out_ready
module serial_alu_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [3:0]       op_q;
  logic             slt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_flag_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;

  logic             slt_req;
  logic [3:0]       op_load;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] result_d;
  logic             ovf_bit;
  logic             add_class;
  logic             last_bit;

`ifdef SERIAL_ALU_SLT_EN
  assign slt_req = (op == 4'b0111);
`else
  assign slt_req = 1'b0;
`endif

  // SLT runs the slice as a plain subtract; the flag is rebuilt at the end
  assign op_load   = slt_req ? 4'b0110 : op;
  assign res_d     = {alu_result, res_sh_q[WIDTH-1:1]};
  assign ovf_bit   = carry_q ^ alu_cout;
  assign add_class = (op_q[1:0] == 2'b10) && !slt_q;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign result_d  = slt_q ? {{(WIDTH-1){1'b0}}, res_d[WIDTH-1] ^ ovf_bit} : res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_sh_q     <= '0;
      op_q         <= '0;
      slt_q        <= 1'b0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      carry_flag_q <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            res_sh_q   <= '0;
            op_q       <= op_load;
            slt_q      <= slt_req;
            cnt_q      <= '0;
            carry_q    <= ((op_load[1:0] == 2'b10) && op_load[2]);
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_d;
          carry_q  <= alu_cout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // carry_q here is the carry into the MSB, alu_cout the carry out of it
            result_q     <= result_d;
            zero_q       <= (result_d == '0);
            carry_flag_q <= add_class ? alu_cout : 1'b0;
            ovf_q        <= add_class ? ovf_bit : 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_flag_q;
  assign overflow  = ovf_q;

  assign alu_a   = (state_q == S_RUN) && a_sh_q[0];
  assign alu_b   = (state_q == S_RUN) && b_sh_q[0];
  assign alu_cin = (state_q == S_RUN) && carry_q;
  assign alu_op  = op_q;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed bench for serial_alu_ctrl with a behavioural 1-bit slice and a result scoreboard.
module tb_serial_alu_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic [3:0]   alu_op;
  logic         alu_result;
  logic         alu_cout;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // behavioural alu1Bit
  logic sa, sb;
  always_comb begin
    sa = alu_op[3] ? ~alu_a : alu_a;
    sb = alu_op[2] ? ~alu_b : alu_b;
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    case (alu_op[1:0])
      2'b00: alu_result = sa & sb;
      2'b01: alu_result = sa | sb;
      2'b10: begin
        alu_result = sa ^ sb ^ alu_cin;
        alu_cout   = (sa & sb) | (sa & alu_cin) | (sb & alu_cin);
      end
      default: alu_result = 1'b0;
    endcase
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  logic fa, fb, fc;
  logic [3:0] fo;

  function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [3:0] o);
    logic [W-1:0] aa, bb;
    logic [W:0]   s;
    exp_t e;
    e  = '0;
    aa = o[3] ? ~x : x;
    bb = o[2] ? ~y : y;
    case (o[1:0])
      2'b00: e.r = aa & bb;
      2'b01: e.r = aa | bb;
      2'b10: begin
        s   = {1'b0, aa} + {1'b0, bb} + (W+1)'(o[2]);
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
      end
      default: e.r = '0;
    endcase
`ifdef SERIAL_ALU_SLT_EN
    if (o == 4'b0111) begin
      e.r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      e.c = 1'b0;
      e.v = 1'b0;
    end
`endif
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [3:0] iop, input int hold, input string tag);
    int   edges;
    exp_t e;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    q.push_back(ref_model(ia, ib, iop));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    fa = alu_a; fb = alu_b; fc = alu_cin; fo = alu_op;
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 4*W) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(W+1));
    if (out_valid !== 1'b1) begin
      void'(q.pop_front());
      return;
    end
    e = q.pop_front();
    chk({tag, "_result"}, 64'(result), 64'(e.r));
    chk({tag, "_zero"}, 64'(zero), 64'(e.z));
    chk({tag, "_carry"}, 64'(carry), 64'(e.c));
    chk({tag, "_overflow"}, 64'(overflow), 64'(e.v));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_result"}, 64'({result, zero, carry, overflow}), 64'(e));
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    chk({tag, "_result_kept"}, 64'(result), 64'(e.r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0011, 4'b1101, 4'b1010};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'({result, zero, carry, overflow}), 64'd0);
    chk("rst_slice", 64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
    rst_n = 1'b1;

    run_op(8'h7F, 8'h01, 4'b0010, 0, "add");
    chk("add_const", 64'({result, zero, carry, overflow}), 64'({8'h80, 1'b0, 1'b0, 1'b1}));

    run_op(8'h05, 8'h05, 4'b0110, 0, "sub");
    chk("sub_const", 64'({result, zero, carry, overflow}), 64'({8'h00, 1'b1, 1'b1, 1'b0}));
    chk("sub_first_cin", 64'(fc), 64'd1);
    chk("sub_first_op", 64'(fo), 64'(4'b0110));
    chk("sub_first_a", 64'(fa), 64'd1);
    chk("sub_first_b_eff", 64'(fb ^ fo[2]), 64'd0);

    run_op(8'hF0, 8'h3C, 4'b0000, 0, "and");
    chk("and_const", 64'(result), 64'(8'h30));
    run_op(8'hF0, 8'h3C, 4'b0001, 0, "or");
    chk("or_const", 64'(result), 64'(8'hFC));
    run_op(8'hF0, 8'h3C, 4'b1100, 0, "nor");
    chk("nor_const", 64'(result), 64'(8'h03));
    chk("nor_flags", 64'({carry, overflow}), 64'd0);

    run_op(8'h12, 8'h34, 4'b0010, 5, "bp");
    run_op(8'h80, 8'h80, 4'b0010, 0, "b2b");
    chk("b2b_const", 64'({result, zero, carry, overflow}), 64'({8'h00, 1'b1, 1'b1, 1'b1}));
    run_op(8'hAA, 8'h55, 4'b0011, 0, "nofunc");
    run_op(8'hFE, 8'h01, 4'b0111, 0, "slt_a");
`ifdef SERIAL_ALU_SLT_EN
    chk("slt_a_const", 64'(result), 64'(8'h01));
    run_op(8'h01, 8'hFE, 4'b0111, 0, "slt_b");
    chk("slt_b_const", 64'({result, zero}), 64'({8'h00, 1'b1}));
`else
    chk("op0111_const", 64'({result, zero}), 64'({8'h00, 1'b1}));
`endif

    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), ops[$urandom_range(0, 7)], i % 2, "rand");

    run_op(8'h0F, 8'h01, 4'b0001, 0, "pre_rst");
    @(negedge clk);
    a = 8'hFF; b = 8'h01; op = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_outputs", 64'({out_valid, result, zero, carry, overflow}), 64'd0);
    chk("mid_rst_slice", 64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
    repeat (2) @(posedge clk);
    #1 chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h02, 8'h03, 4'b0010, 0, "post_rst");
    chk("post_rst_const", 64'(result), 64'(8'h05));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
